// File: rtl/ddfs_phase_generator_if.sv
// Angle stream handshake between the DDFS phase generator (master) and the
// CORDIC consumer (slave).
interface ddfs_phase_generator_if #(
  parameter int unsigned W = 32
);
  logic         angle_valid;
  logic         angle_ready;
  logic [W-1:0] angle_out;
  logic         quad_flip;

  modport master (
    output angle_valid,
    output angle_out,
    output quad_flip,
    input  angle_ready
  );

  modport slave (
    input  angle_valid,
    input  angle_out,
    input  quad_flip,
    output angle_ready
  );
endinterface

// File: rtl/ddfs_phase_generator.sv
// DDFS phase generator: accumulates a Q3.28 radian phase modulo 2*pi, folds it
// into [-pi/2, +pi/2] for the CORDIC core and flags quadrants 2/3 so the
// consumer negates its cosine. One angle is delivered per valid/ready transfer.
// Optional build macro: DDFS_PHASE_DITHER_EN adds LFSR dither on the angle LSBs.
module ddfs_phase_generator #(
  parameter int unsigned  W           = 32,
  parameter logic [W-1:0] RESET_FWORD = W'(32'h00477D1A),
  parameter int unsigned  DITHER_BITS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   phase_clr,
  input  logic                   freq_load,
  input  logic [W-1:0]           freq_word_in,
  ddfs_phase_generator_if.master ang,
  output logic                   freq_err
);

  localparam logic [W-1:0] PI_HALF       = W'(421657428);
  localparam logic [W-1:0] PI            = W'(843314857);
  localparam logic [W-1:0] THREE_PI_HALF = W'(1264972285);
  localparam logic [W-1:0] TWO_PI        = W'(1686629713);

  localparam logic signed [W-1:0] ANGLE_MAX = $signed(PI_HALF);
  localparam logic signed [W-1:0] ANGLE_MIN = -ANGLE_MAX;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [W-1:0]           phase_q, phase_d;
  logic [W-1:0]           fword_q, fword_d;
  logic [W-1:0]           angle_q, angle_d;
  logic                   flip_q, flip_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   xfer_c;
  logic [W-1:0]           phase_inc_c;
  logic [DITHER_BITS-1:0] dither_c;

  // Phase step modulo 2*pi; both operands are below 2*pi so one subtract suffices.
  function automatic logic [W-1:0] wrap_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, TWO_PI}) s = s - {1'b0, TWO_PI};
    return s[W-1:0];
  endfunction

  // Map [0, 2*pi) onto [-pi/2, +pi/2]; MSB of the result is the cosine flip.
  function automatic logic [W:0] fold(input logic [W-1:0] p);
    if (p <= PI_HALF)          return {1'b0, p};
    else if (p < THREE_PI_HALF) return {1'b1, PI - p};
    else                        return {1'b0, p - TWO_PI};
  endfunction

  // Fold, perturb the low bits by the dither word, then keep within range.
  function automatic logic [W:0] sample(input logic [W-1:0] p, input logic [DITHER_BITS-1:0] d);
    logic [W:0]          f;
    logic signed [W-1:0] x;
    f = fold(p);
    x = $signed(f[W-1:0] ^ W'(d));
    if (x > ANGLE_MAX)      x = ANGLE_MAX;
    else if (x < ANGLE_MIN) x = ANGLE_MIN;
    return {f[W], $unsigned(x)};
  endfunction

  assign xfer_c      = valid_q & ang.angle_ready;
  assign phase_inc_c = wrap_add(phase_q, fword_q);

`ifdef DDFS_PHASE_DITHER_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois LFSR x^16+x^14+x^13+x^11+1, stepped once per accepted sample.
  always_comb begin
    lfsr_d = lfsr_q;
    if (xfer_c) lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // LFSR state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lfsr_q <= 16'hACE1;
    else          lfsr_q <= lfsr_d;
  end

  assign dither_c = lfsr_q[DITHER_BITS-1:0];
`else
  assign dither_c = '0;
`endif

  // Next-state, phase/frequency update and output sample selection.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    fword_d = fword_q;
    angle_d = angle_q;
    flip_d  = flip_q;
    valid_d = valid_q;
    err_d   = err_q;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (enable) begin
          state_d           = ST_RUN;
          valid_d           = 1'b1;
          {flip_d, angle_d} = sample(phase_clr ? W'(0) : phase_q, dither_c);
        end
      end
      ST_RUN: begin
        if (xfer_c) begin
          phase_d           = phase_inc_c;
          {flip_d, angle_d} = sample(phase_inc_c, dither_c);
        end
        if (!enable) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (xfer_c) begin
          phase_d           = phase_inc_c;
          {flip_d, angle_d} = sample(phase_inc_c, dither_c);
        end
        if (enable) begin
          state_d = ST_RUN;
        end else if (xfer_c) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase

    // Phase restart wins over any increment and replaces a pending sample.
    if (phase_clr) begin
      phase_d = '0;
      if (valid_q) {flip_d, angle_d} = sample(W'(0), dither_c);
    end

    if (freq_load) begin
      if (freq_word_in < TWO_PI) begin
        fword_d = freq_word_in;
      end else begin
        fword_d = TWO_PI - W'(1);
        err_d   = 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      fword_q <= RESET_FWORD;
      angle_q <= '0;
      flip_q  <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      fword_q <= fword_d;
      angle_q <= angle_d;
      flip_q  <= flip_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign ang.angle_valid = valid_q;
  assign ang.angle_out   = angle_q;
  assign ang.quad_flip   = flip_q;
  assign freq_err        = err_q;

endmodule

// File: tb/tb_ddfs_phase_generator.sv
// Self-checking bench for ddfs_phase_generator (dither build macro undefined).
module tb_ddfs_phase_generator;

  localparam int unsigned W = 32;
  localparam longint PI_HALF       = 421657428;
  localparam longint PI            = 843314857;
  localparam longint THREE_PI_HALF = 1264972285;
  localparam longint TWO_PI        = 1686629713;
  localparam longint F0            = 4685082;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         enable;
  logic         phase_clr;
  logic         freq_load;
  logic [W-1:0] freq_word_in;
  logic         freq_err;

  ddfs_phase_generator_if #(.W(W)) bus ();

  ddfs_phase_generator #(.W(W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .phase_clr    (phase_clr),
    .freq_load    (freq_load),
    .freq_word_in (freq_word_in),
    .ang          (bus),
    .freq_err     (freq_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase of the offered sample, frequency word, handshake flags.
  longint m_phase;
  longint m_fword;
  bit     m_valid;
  bit     m_drain;
  bit     m_err;

  function automatic longint exp_angle(input longint p);
    if (p <= PI_HALF)            return p;
    else if (p < THREE_PI_HALF)  return PI - p;
    else                         return p - TWO_PI;
  endfunction

  function automatic bit exp_flip(input longint p);
    return (p > PI_HALF) && (p < THREE_PI_HALF);
  endfunction

  function automatic longint got_angle();
    return longint'($signed(bus.angle_out));
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_fword = F0;
    m_valid = 1'b0;
    m_drain = 1'b0;
    m_err   = 1'b0;
  endtask

  // Apply one clock edge of the specified behaviour to the model.
  task automatic model_edge();
    bit xfer;
    xfer = m_valid && bus.angle_ready;
    if (phase_clr)  m_phase = 0;
    else if (xfer)  m_phase = (m_phase + m_fword) % TWO_PI;
    if (!m_valid) begin
      m_valid = enable;
      m_drain = 1'b0;
    end else if (xfer && m_drain && !enable) begin
      m_valid = 1'b0;
    end else begin
      m_drain = !enable;
    end
    if (freq_load) begin
      if (longint'(freq_word_in) < TWO_PI) begin
        m_fword = longint'(freq_word_in);
      end else begin
        m_fword = TWO_PI - 1;
        m_err   = 1'b1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    enable           = 1'b0;
    phase_clr        = 1'b0;
    freq_load        = 1'b0;
    freq_word_in     = '0;
    bus.angle_ready  = 1'b0;
    reset_n          = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.angle_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", bus.angle_valid); end
    checks++; if (bus.angle_out !== '0) begin failures++; $display("FAIL reset_angle: got %0d expected 0", got_angle()); end
    checks++; if (bus.quad_flip !== 1'b0) begin failures++; $display("FAIL reset_flip: got %0b expected 0", bus.quad_flip); end
    checks++; if (freq_err !== 1'b0) begin failures++; $display("FAIL reset_freq_err: got %0b expected 0", freq_err); end
  endtask

  task automatic test_sweep();
    longint a;
    do_reset();
    enable = 1'b1;
    bus.angle_ready = 1'b1;
    cyc();
    checks++; if (bus.angle_valid !== 1'b1 || got_angle() != 0) begin failures++; $display("FAIL sweep_first: got valid=%0b angle=%0d expected valid=1 angle=0", bus.angle_valid, got_angle()); end
    for (int k = 1; k <= 360; k++) begin
      cyc();
      if (k <= 90) begin
        checks++; if (got_angle() != longint'(k) * F0 || bus.quad_flip !== 1'b0) begin failures++; $display("FAIL sweep_k%0d: got angle=%0d flip=%0b expected angle=%0d flip=0", k, got_angle(), bus.quad_flip, longint'(k) * F0); end
      end
    end
    a = got_angle();
    checks++; if (a > 360 || a < -360) begin failures++; $display("FAIL sweep_wrap_err: got %0d expected |angle|<=360", a); end
    checks++; if (a != exp_angle(m_phase)) begin failures++; $display("FAIL sweep_wrap_exact: got %0d expected %0d", a, exp_angle(m_phase)); end
  endtask

  task automatic test_quadrants();
    longint p;
    do_reset();
    freq_word_in = W'(PI_HALF);
    freq_load    = 1'b1;
    cyc();
    freq_load       = 1'b0;
    enable          = 1'b1;
    bus.angle_ready = 1'b1;
    cyc();
    for (int k = 0; k <= 4; k++) begin
      p = (longint'(k) * PI_HALF) % TWO_PI;
      checks++; if (got_angle() != exp_angle(p) || bus.quad_flip !== exp_flip(p)) begin failures++; $display("FAIL quad_k%0d: got angle=%0d flip=%0b expected angle=%0d flip=%0b", k, got_angle(), bus.quad_flip, exp_angle(p), exp_flip(p)); end
      if (k == 1) begin
        checks++; if (got_angle() != PI_HALF || bus.quad_flip !== 1'b0) begin failures++; $display("FAIL quad_pi_half_boundary: got angle=%0d flip=%0b expected angle=%0d flip=0", got_angle(), bus.quad_flip, PI_HALF); end
      end
      cyc();
    end
    do_reset();
    freq_word_in = W'(THREE_PI_HALF);
    freq_load    = 1'b1;
    cyc();
    freq_load       = 1'b0;
    enable          = 1'b1;
    bus.angle_ready = 1'b1;
    cyc();
    cyc();
    checks++; if (got_angle() != -PI_HALF || bus.quad_flip !== 1'b0) begin failures++; $display("FAIL quad_three_pi_half_boundary: got angle=%0d flip=%0b expected angle=%0d flip=0", got_angle(), bus.quad_flip, -PI_HALF); end
    cyc();
    checks++; if (got_angle() != 0 || bus.quad_flip !== 1'b1) begin failures++; $display("FAIL quad_pi: got angle=%0d flip=%0b expected angle=0 flip=1", got_angle(), bus.quad_flip); end
  endtask

  task automatic test_backpressure();
    longint held_a;
    logic   held_f;
    do_reset();
    enable          = 1'b1;
    bus.angle_ready = 1'b1;
    cyc();
    repeat (10) cyc();
    held_a = got_angle();
    held_f = bus.quad_flip;
    checks++; if (held_a != 10 * F0) begin failures++; $display("FAIL bp_before: got %0d expected %0d", held_a, 10 * F0); end
    bus.angle_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      checks++; if (bus.angle_valid !== 1'b1 || got_angle() != held_a || bus.quad_flip !== held_f) begin failures++; $display("FAIL bp_hold_%0d: got valid=%0b angle=%0d flip=%0b expected valid=1 angle=%0d flip=%0b", i, bus.angle_valid, got_angle(), bus.quad_flip, held_a, held_f); end
    end
    bus.angle_ready = 1'b1;
    cyc();
    checks++; if (got_angle() != 11 * F0) begin failures++; $display("FAIL bp_resume1: got %0d expected %0d", got_angle(), 11 * F0); end
    cyc();
    checks++; if (got_angle() != 12 * F0) begin failures++; $display("FAIL bp_resume2: got %0d expected %0d", got_angle(), 12 * F0); end
  endtask

  task automatic test_freq_load();
    do_reset();
    freq_word_in = 32'h7000_0000;
    freq_load    = 1'b1;
    cyc();
    checks++; if (freq_err !== 1'b1) begin failures++; $display("FAIL freq_err_set: got %0b expected 1", freq_err); end
    freq_word_in = 32'hFFFF_FFFF;
    cyc();
    freq_load       = 1'b0;
    enable          = 1'b1;
    bus.angle_ready = 1'b1;
    cyc();
    checks++; if (got_angle() != 0) begin failures++; $display("FAIL freq_first: got %0d expected 0", got_angle()); end
    cyc();
    checks++; if (got_angle() != -1 || bus.quad_flip !== 1'b0) begin failures++; $display("FAIL freq_clamped_word: got angle=%0d flip=%0b expected angle=-1 flip=0", got_angle(), bus.quad_flip); end
    freq_word_in = W'(1000);
    freq_load    = 1'b1;
    cyc();
    freq_load = 1'b0;
    checks++; if (got_angle() != -2) begin failures++; $display("FAIL freq_load_cycle_old_word: got %0d expected -2", got_angle()); end
    cyc();
    checks++; if (got_angle() != 998) begin failures++; $display("FAIL freq_new_word: got %0d expected 998", got_angle()); end
    checks++; if (freq_err !== 1'b1) begin failures++; $display("FAIL freq_err_sticky: got %0b expected 1", freq_err); end
  endtask

  task automatic test_phase_clr();
    do_reset();
    freq_word_in = W'(PI);
    freq_load    = 1'b1;
    cyc();
    freq_load       = 1'b0;
    enable          = 1'b1;
    bus.angle_ready = 1'b1;
    cyc();
    cyc();
    checks++; if (got_angle() != 0 || bus.quad_flip !== 1'b1) begin failures++; $display("FAIL clr_at_pi: got angle=%0d flip=%0b expected angle=0 flip=1", got_angle(), bus.quad_flip); end
    phase_clr = 1'b1;
    cyc();
    phase_clr = 1'b0;
    checks++; if (got_angle() != 0 || bus.quad_flip !== 1'b0 || bus.angle_valid !== 1'b1) begin failures++; $display("FAIL clr_with_xfer: got angle=%0d flip=%0b valid=%0b expected angle=0 flip=0 valid=1", got_angle(), bus.quad_flip, bus.angle_valid); end
    cyc();
    checks++; if (got_angle() != 0 || bus.quad_flip !== 1'b1) begin failures++; $display("FAIL clr_restart: got angle=%0d flip=%0b expected angle=0 flip=1", got_angle(), bus.quad_flip); end
    bus.angle_ready = 1'b0;
    phase_clr       = 1'b1;
    cyc();
    phase_clr = 1'b0;
    checks++; if (got_angle() != 0 || bus.quad_flip !== 1'b0 || bus.angle_valid !== 1'b1) begin failures++; $display("FAIL clr_held: got angle=%0d flip=%0b valid=%0b expected angle=0 flip=0 valid=1", got_angle(), bus.quad_flip, bus.angle_valid); end
  endtask

  task automatic test_drain_and_reset();
    do_reset();
    enable          = 1'b1;
    bus.angle_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    bus.angle_ready = 1'b0;
    enable          = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (bus.angle_valid !== 1'b1 || got_angle() != 2 * F0) begin failures++; $display("FAIL drain_hold_%0d: got valid=%0b angle=%0d expected valid=1 angle=%0d", i, bus.angle_valid, got_angle(), 2 * F0); end
    end
    bus.angle_ready = 1'b1;
    cyc();
    checks++; if (bus.angle_valid !== 1'b0) begin failures++; $display("FAIL drain_done: got valid=%0b expected 0", bus.angle_valid); end
    bus.angle_ready = 1'b0;
    cyc();
    checks++; if (bus.angle_valid !== 1'b0) begin failures++; $display("FAIL drain_idle: got valid=%0b expected 0", bus.angle_valid); end
    enable = 1'b1;
    cyc();
    checks++; if (bus.angle_valid !== 1'b1 || got_angle() != 3 * F0) begin failures++; $display("FAIL drain_restart: got valid=%0b angle=%0d expected valid=1 angle=%0d", bus.angle_valid, got_angle(), 3 * F0); end
    enable = 1'b0;
    cyc();
    enable = 1'b1;
    cyc();
    bus.angle_ready = 1'b1;
    cyc();
    checks++; if (bus.angle_valid !== 1'b1 || got_angle() != 4 * F0) begin failures++; $display("FAIL drain_reenable: got valid=%0b angle=%0d expected valid=1 angle=%0d", bus.angle_valid, got_angle(), 4 * F0); end
    freq_word_in = 32'hFFFF_FFFF;
    freq_load    = 1'b1;
    cyc();
    freq_load = 1'b0;
    checks++; if (freq_err !== 1'b1) begin failures++; $display("FAIL pre_reset_err: got %0b expected 1", freq_err); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.angle_valid !== 1'b0 || bus.angle_out !== '0 || bus.quad_flip !== 1'b0 || freq_err !== 1'b0) begin failures++; $display("FAIL async_reset: got valid=%0b angle=%0d flip=%0b err=%0b expected all 0", bus.angle_valid, got_angle(), bus.quad_flip, freq_err); end
    model_reset();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      enable          = ($urandom_range(0, 9) != 0);
      bus.angle_ready = ($urandom_range(0, 3) != 0);
      phase_clr       = ($urandom_range(0, 39) == 0);
      freq_load       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0) freq_word_in = $urandom;
      else                           freq_word_in = $urandom_range(0, 32'd1686629712);
      cyc();
      checks++; if (bus.angle_valid !== m_valid) begin failures++; $display("FAIL rand_valid @%0d: got %0b expected %0b", i, bus.angle_valid, m_valid); end
      if (m_valid) begin
        checks++; if (got_angle() != exp_angle(m_phase) || bus.quad_flip !== exp_flip(m_phase)) begin failures++; $display("FAIL rand_angle @%0d: got angle=%0d flip=%0b expected angle=%0d flip=%0b", i, got_angle(), bus.quad_flip, exp_angle(m_phase), exp_flip(m_phase)); end
      end
      checks++; if (freq_err !== m_err) begin failures++; $display("FAIL rand_err @%0d: got %0b expected %0b", i, freq_err, m_err); end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_sweep();
    test_quadrants();
    test_backpressure();
    test_freq_load();
    test_phase_clr();
    test_drain_and_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
